// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP sample requester: FSM states,
// quadrant codes and window geometry.
package lbp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] ANG_NE = 2'd0;
  localparam logic [1:0] ANG_NW = 2'd1;
  localparam logic [1:0] ANG_SW = 2'd2;
  localparam logic [1:0] ANG_SE = 2'd3;

  localparam int unsigned WIN_DIM = 7;
  localparam int unsigned CTR     = 3;
  localparam int unsigned WIN_PIX = WIN_DIM * WIN_DIM;

  // Uniform pattern: at most two 0/1 transitions around the circular code.
  function automatic logic lbp_is_uniform(input logic [7:0] v);
    return $countones(v ^ {v[0], v[7:1]}) <= 2;
  endfunction

endpackage

// File: rtl/lbp_corner_sel.sv
// Combinational window tap: the four bilinear corners for one quadrant and
// the on-axis pixel that precedes that quadrant in LBP bit order.
module lbp_corner_sel
  import lbp_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic [WIN_PIX*PIX_W-1:0] win,
  input  logic [1:0]               rl,
  input  logic [1:0]               angle,
  output logic [PIX_W-1:0]         a,
  output logic [PIX_W-1:0]         b,
  output logic [PIX_W-1:0]         c,
  output logic [PIX_W-1:0]         d,
  output logic [PIX_W-1:0]         axis,
  output logic [PIX_W-1:0]         centre
);

  localparam logic [2:0] MID = 3'(CTR);

  logic [PIX_W-1:0] pix [WIN_DIM][WIN_DIM];
  logic [2:0]       f;
  logic [2:0]       rad;
  logic [2:0]       row_n;
  logic [2:0]       row_f;
  logic [2:0]       col_n;
  logic [2:0]       col_f;
  logic             up;
  logic             right;

  for (genvar gr = 0; gr < WIN_DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < WIN_DIM; gc++) begin : g_col
      assign pix[gr][gc] = win[(gr*WIN_DIM+gc)*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    // A radius code of 0 behaves as 1, which also keeps taps in range after reset.
    f     = (rl == 2'd0) ? 3'd0 : {1'b0, rl} - 3'd1;
    rad   = f + 3'd1;
    up    = (angle == ANG_NE) || (angle == ANG_NW);
    right = (angle == ANG_NE) || (angle == ANG_SE);
    row_n = up    ? MID - f   : MID + f;
    row_f = up    ? MID - rad : MID + rad;
    col_n = right ? MID + f   : MID - f;
    col_f = right ? MID + rad : MID - rad;
    a     = pix[row_n][col_n];
    b     = pix[row_n][col_f];
    c     = pix[row_f][col_n];
    d     = pix[row_f][col_f];
    // Quadrant k pairs with axis E, N, W, S so axis/diagonal bits interleave.
    unique case (angle)
      ANG_NE:  axis = pix[MID][MID + rad];
      ANG_NW:  axis = pix[MID - rad][MID];
      ANG_SW:  axis = pix[MID][MID - rad];
      default: axis = pix[MID + rad][MID];
    endcase
  end

  assign centre = pix[MID][MID];

endmodule

// File: rtl/lbp_sample_requester.sv
// LBP sample requester: issues four diagonal interpolation requests per window
// and assembles the 8-bit LBP code. Optional `uniform` output via LBP_UNIFORM_EN.
module lbp_sample_requester
  import lbp_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned WAIT_MAX = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIN_PIX*PIX_W-1:0] win,
  input  logic [1:0]               radius,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PIX_W-1:0]         A,
  output logic [PIX_W-1:0]         B,
  output logic [PIX_W-1:0]         C,
  output logic [PIX_W-1:0]         D,
  output logic [1:0]               r,
  output logic [1:0]               angle,
  output logic                     req_valid,
  input  logic [PIX_W-1:0]         I,
  input  logic                     z,
  output logic [7:0]               code,
  output logic                     err,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef LBP_UNIFORM_EN
  ,
  output logic                     uniform
`endif
);

  localparam int unsigned       WD_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WD_W-1:0]   WD_LIM = WD_W'(WAIT_MAX);

  state_t                   state_q, state_d;
  logic [WIN_PIX*PIX_W-1:0] win_q, win_d;
  logic [1:0]               rl_q, rl_d;
  logic [1:0]               req_cnt_q, req_cnt_d;
  logic [2:0]               ret_cnt_q, ret_cnt_d;
  logic [WD_W-1:0]          wd_cnt_q, wd_cnt_d;
  logic [7:0]               code_q, code_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic                     take_ret;
  logic                     ret_done;
  logic                     wd_expire;
  logic [PIX_W-1:0]         sel_a, sel_b, sel_c, sel_d, sel_axis, sel_ctr;

  lbp_corner_sel #(.PIX_W(PIX_W)) u_sel (
    .win    (win_q),
    .rl     (rl_q),
    .angle  (req_cnt_q),
    .a      (sel_a),
    .b      (sel_b),
    .c      (sel_c),
    .d      (sel_d),
    .axis   (sel_axis),
    .centre (sel_ctr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      rl_q      <= '0;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
      wd_cnt_q  <= '0;
      code_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rl_q      <= rl_d;
      req_cnt_q <= req_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      code_q    <= code_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (req_cnt_q == 2'd3) state_d = ST_WAIT;
      ST_WAIT:  if (ret_done || wd_expire) state_d = ST_DONE;
      default:  if (out_ready) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = in_valid && in_ready;
    ret_done  = (ret_cnt_q == 3'd4);
    take_ret  = z && !ret_cnt_q[2] && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));
    win_d     = win_q;
    rl_d      = rl_q;
    req_cnt_d = req_cnt_q;
    ret_cnt_d = ret_cnt_q;
    code_d    = code_q;
    err_d     = err_q;
    wd_cnt_d  = '0;
    if (state_q == ST_WAIT && !z) begin
      wd_cnt_d = (wd_cnt_q == WD_LIM) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
    wd_expire = (state_q == ST_WAIT) && !ret_done && (wd_cnt_d == WD_LIM);

    if (state_q == ST_IDLE && accept) begin
      win_d     = win;
      rl_d      = (radius == 2'd0) ? 2'd1 : radius;
      req_cnt_d = '0;
      ret_cnt_d = '0;
      code_d    = '0;
      err_d     = 1'b0;
    end
    if (state_q == ST_ISSUE) begin
      code_d[{req_cnt_q, 1'b0}] = (sel_axis >= sel_ctr);
      // Counter parks at 3 so angle keeps the last quadrant while idle.
      if (req_cnt_q != 2'd3) req_cnt_d = req_cnt_q + 2'd1;
    end
    if (take_ret) begin
      code_d[{ret_cnt_q[1:0], 1'b1}] = (I >= sel_ctr);
      ret_cnt_d = ret_cnt_q + 3'd1;
    end
    if (wd_expire) err_d = 1'b1;
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    req_valid = (state_q == ST_ISSUE);
    out_valid = (state_q == ST_DONE);
    A         = sel_a;
    B         = sel_b;
    C         = sel_c;
    D         = sel_d;
    r         = rl_q;
    angle     = req_cnt_q;
    code      = code_q;
    err       = err_q;
  end

`ifdef LBP_UNIFORM_EN
  logic uniform_q, uniform_d;

  always_comb begin
    uniform_d = uniform_q;
    if (state_d == ST_DONE && state_q != ST_DONE) uniform_d = lbp_is_uniform(code_d);
  end

  always_ff @(posedge clk) begin
    if (rst) uniform_q <= 1'b0;
    else     uniform_q <= uniform_d;
  end

  assign uniform = uniform_q;
`endif

endmodule

// File: tb/tb_lbp_sample_requester.sv
// Directed plus randomized bench for lbp_sample_requester with a behavioural
// interpolator (fixed latency, in-order returns) and an LBP reference model.
module tb_lbp_sample_requester;

  localparam int unsigned WAIT_MAX = 31;

  logic          clk;
  logic          rst;
  logic [391:0]  win;
  logic [1:0]    radius;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    A, B, C, D;
  logic [1:0]    r;
  logic [1:0]    angle;
  logic          req_valid;
  logic [7:0]    I;
  logic          z;
  logic [7:0]    code;
  logic          err;
  logic          out_valid;
  logic          out_ready;

  lbp_sample_requester #(.PIX_W(8), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .win       (win),
    .radius    (radius),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .r         (r),
    .angle     (angle),
    .req_valid (req_valid),
    .I         (I),
    .z         (z),
    .code      (code),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Job context shared with the interpolator model.
  logic [7:0]  pix [7][7];
  logic [7:0]  rv  [4];
  int          rl_m     = 1;
  int unsigned lat      = 0;
  bit          ret_en   = 1'b1;
  int unsigned req_idx  = 0;
  bit          stray_req = 1'b0;

  bit          pv  [8];
  logic [7:0]  piv [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] corner(input int ang, input int dri, input int dci);
    int dr, dc, f;
    dr = (ang <= 1) ? -1 : 1;
    dc = (ang == 0 || ang == 3) ? 1 : -1;
    f  = rl_m - 1;
    return pix[3 + dr*(f+dri)][3 + dc*(f+dci)];
  endfunction

  function automatic logic [7:0] ref_code(input int rl);
    logic [7:0] s [8];
    logic [7:0] res;
    s[0] = pix[3][3+rl];
    s[2] = pix[3-rl][3];
    s[4] = pix[3][3-rl];
    s[6] = pix[3+rl][3];
    for (int k = 0; k < 4; k++) s[2*k+1] = rv[k];
    for (int i = 0; i < 8; i++) res[i] = (s[i] >= pix[3][3]);
    return res;
  endfunction

  task automatic pack_win();
    for (int rr = 0; rr < 7; rr++)
      for (int cc = 0; cc < 7; cc++)
        win[(rr*7+cc)*8 +: 8] = pix[rr][cc];
  endtask

  task automatic fill(input int unsigned lo, input int unsigned hi);
    for (int rr = 0; rr < 7; rr++)
      for (int cc = 0; cc < 7; cc++)
        pix[rr][cc] = 8'($urandom_range(hi, lo));
  endtask

  task automatic fill_rv(input int unsigned lo, input int unsigned hi);
    for (int k = 0; k < 4; k++) rv[k] = 8'($urandom_range(hi, lo));
  endtask

  // Interpolator model: checks every request and answers after `lat` cycles.
  initial begin
    z = 1'b0;
    I = '0;
    for (int i = 0; i < 8; i++) piv[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
        pv[i]  = pv[i+1];
        piv[i] = piv[i+1];
      end
      pv[7] = 1'b0;
      if (req_valid === 1'b1) begin
        check("req_angle", angle, req_idx % 4);
        check("req_r", r, rl_m);
        check("req_A", A, corner(int'(req_idx % 4), 0, 0));
        check("req_B", B, corner(int'(req_idx % 4), 0, 1));
        check("req_C", C, corner(int'(req_idx % 4), 1, 0));
        check("req_D", D, corner(int'(req_idx % 4), 1, 1));
        if (ret_en && req_idx < 4) begin
          pv[lat]  = 1'b1;
          piv[lat] = rv[req_idx];
        end
        req_idx++;
      end
      if (stray_req) begin
        pv[0]     = 1'b1;
        piv[0]    = 8'hAA;
        stray_req = 1'b0;
      end
      z = pv[0];
      I = piv[0];
    end
  end

  task automatic run_job(input logic [1:0] rad, input int unsigned l, input bit en,
                         input int unsigned hold, output logic [7:0] got);
    int unsigned n;
    bit          seen;
    logic [7:0]  exp;
    int unsigned exp_lat;
    rl_m    = (rad == 2'd0) ? 1 : int'(rad);
    lat     = l;
    ret_en  = en;
    req_idx = 0;
    exp     = ref_code(rl_m);
    exp_lat = en ? 5 + l : 4 + WAIT_MAX;
    @(negedge clk);
    pack_win();
    radius   = rad;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = (out_valid === 1'b1);
    end
    check("out_valid_seen", seen, 1);
    check("latency", n, exp_lat);
    check("err", err, !en);
    check("req_count", req_idx, 4);
    if (en) check("code", code, exp);
    got = code;
    repeat (hold) begin
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_code", code, got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] got;
    rst       = 1'b1;
    win       = '0;
    radius    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fill(0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_code", code, 0);
    check("rst_err", err, 0);
    check("rst_A", A, 0);
    check("rst_r", r, 0);
    check("rst_angle", angle, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Flat window: every comparison is an equality, so all bits set.
    fill(50, 50);
    fill_rv(50, 50);
    run_job(2'd1, 2, 1'b1, 0, got);
    check("flat_code", got, 8'hFF);

    // Largest radius: corners reach the window edge.
    fill(0, 255);
    fill_rv(0, 255);
    run_job(2'd3, 1, 1'b1, 0, got);

    // Radius code 0 behaves as 1.
    fill(200, 200);
    pix[3][3] = 8'd100;
    pix[3][4] = 8'd99;
    fill_rv(10, 10);
    run_job(2'd0, 2, 1'b1, 0, got);
    check("r0_code", got, 8'b0101_0100);

    // Interpolator never answers: watchdog abort.
    fill(0, 255);
    fill_rv(0, 255);
    run_job(2'd2, 0, 1'b0, 2, got);

    // Downstream back-pressure for 10 cycles.
    fill(0, 255);
    fill_rv(0, 255);
    run_job(2'd1, 3, 1'b1, 10, got);

    // Reset while waiting with two returns already in.
    fill(0, 255);
    fill_rv(0, 255);
    rl_m = 2; lat = 3; ret_en = 1'b1; req_idx = 0;
    @(negedge clk);
    pack_win();
    radius   = 2'd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle", in_ready, 1);
    check("midrst_req", req_valid, 0);
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_out", out_valid, 0);
    end

    // Explicit stray return while idle, then a job whose code is all zero.
    stray_req = 1'b1;
    repeat (3) @(posedge clk);
    fill(0, 254);
    pix[3][3] = 8'd255;
    fill_rv(0, 254);
    run_job(2'($urandom_range(3, 0)), 2, 1'b1, 0, got);
    check("zero_code", got, 8'h00);

    for (int j = 0; j < 20; j++) begin
      fill(0, 255);
      fill_rv(0, 255);
      run_job(2'($urandom_range(3, 0)), $urandom_range(5, 0), 1'b1,
              $urandom_range(3, 0), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
